// File: rtl/imu_adc_scheduler.sv
// Conversion sequencer for the shared IMU serial ADC: periodic sweeps over a channel
// mask, 2^avg_log2 oversamples per channel, one averaged result per channel.
module imu_adc_scheduler #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [1:0]          avg_log2,
  input  logic                clr_overrun,
  output logic                conv_req,
  output logic [2:0]          conv_ch,
  input  logic                conv_ack,
  input  logic                conv_valid,
  input  logic [DATA_W-1:0]   conv_data,
  output logic                sample_we,
  output logic [2:0]          sample_ch,
  output logic [DATA_W-1:0]   sample_data,
  output logic                sweep_done,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, NEXT} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] period_cnt;
  logic                tick;
  logic [NUM_CH-1:0]   sweep_mask;
  logic [1:0]          sweep_avg;
  logic [DATA_W+2:0]   acc;
  logic [DATA_W+2:0]   acc_sum;
  logic [DATA_W+2:0]   avg_val;
  logic [3:0]          conv_cnt;
  logic [3:0]          cnt_inc;
  logic [3:0]          target;
  logic [2:0]          first_ch;
  logic [2:0]          next_ch;
  logic                first_ok;
  logic                next_ok;

  assign tick = enable && (period_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              period_cnt <= '0;
    else if (!enable)          period_cnt <= '0;
    else if (tick)             period_cnt <= (period == '0) ? '0 : period - PERIOD_W'(1);
    else                       period_cnt <= period_cnt - PERIOD_W'(1);
  end

  assign acc_sum = acc + (DATA_W+3)'(conv_data);
  assign avg_val = acc_sum >> sweep_avg;
  assign cnt_inc = conv_cnt + 4'd1;
  assign target  = 4'd1 << sweep_avg;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    first_ch = '0;
    first_ok = 1'b0;
    next_ch  = '0;
    next_ok  = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (ch_mask[i-1]) begin
        first_ch = 3'(i - 1);
        first_ok = 1'b1;
      end
      if (sweep_mask[i-1] && (3'(i - 1) > conv_ch)) begin
        next_ch = 3'(i - 1);
        next_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sweep_mask  <= '0;
      sweep_avg   <= '0;
      acc         <= '0;
      conv_cnt    <= '0;
      conv_req    <= 1'b0;
      conv_ch     <= '0;
      sample_we   <= 1'b0;
      sample_ch   <= '0;
      sample_data <= '0;
      sweep_done  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sample_we  <= 1'b0;
      sweep_done <= 1'b0;

      if (tick && (state != IDLE)) overrun <= 1'b1;
      else if (clr_overrun)        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            if (first_ok) begin
              sweep_mask <= ch_mask;
              sweep_avg  <= avg_log2;
              conv_ch    <= first_ch;
              conv_req   <= 1'b1;
              busy       <= 1'b1;
              state      <= ISSUE;
            end else begin
              sweep_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (conv_req && conv_ack) begin
            conv_req <= 1'b0;
            state    <= WAIT_DATA;
          end
        end
        // Sample/done decisions are taken on the valid edge so they appear one cycle
        // after the final conversion; NEXT then only re-issues the request.
        WAIT_DATA: begin
          if (conv_valid) begin
            if (cnt_inc < target) begin
              acc      <= acc_sum;
              conv_cnt <= cnt_inc;
              state    <= NEXT;
            end else begin
              sample_we   <= 1'b1;
              sample_ch   <= conv_ch;
              sample_data <= avg_val[DATA_W-1:0];
              acc         <= '0;
              conv_cnt    <= '0;
              if (next_ok) begin
                conv_ch <= next_ch;
                state   <= NEXT;
              end else begin
                sweep_done <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
              end
            end
          end
        end
        NEXT: begin
          conv_req <= 1'b1;
          state    <= ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_adc_scheduler.sv
// Bench for imu_adc_scheduler: behavioural SPI engine, sample scoreboard and
// per-scenario tasks.
module tb_imu_adc_scheduler;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } samp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [19:0] period = '0;
  logic [7:0]  ch_mask = '0;
  logic [1:0]  avg_log2 = '0;
  logic        clr_overrun = 1'b0;
  logic        conv_req;
  logic [2:0]  conv_ch;
  logic        conv_ack = 1'b0;
  logic        conv_valid = 1'b0;
  logic [11:0] conv_data = '0;
  logic        sample_we;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;
  logic        sweep_done;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int ack_dly = 2;
  int val_dly = 5;
  bit spur = 1'b0;
  logic [11:0] data_q[$];
  int hs_cnt = 0;
  int hs_ch[8];
  int vld_cnt = 0;

  samp_t exp_q[$];
  samp_t obs_q[$];
  int sd_cnt = 0;
  int sd_times[$];
  int req_cycles = 0;
  bit busy_seen = 1'b0;

  imu_adc_scheduler #(.NUM_CH(8), .DATA_W(12), .PERIOD_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
    .ch_mask(ch_mask), .avg_log2(avg_log2), .clr_overrun(clr_overrun),
    .conv_req(conv_req), .conv_ch(conv_ch), .conv_ack(conv_ack),
    .conv_valid(conv_valid), .conv_data(conv_data), .sample_we(sample_we),
    .sample_ch(sample_ch), .sample_data(sample_data), .sweep_done(sweep_done),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // SPI engine model: ack after ack_dly request cycles, valid val_dly cycles later.
  initial begin
    int ph = 0;
    int cnt = 0;
    int cur_ch = 0;
    forever begin
      @(negedge clk);
      conv_ack = 1'b0;
      conv_valid = 1'b0;
      if (!reset_n) begin
        ph = 0;
        cnt = 0;
      end else if (ph == 0) begin
        if (conv_req) begin
          if (spur && cnt == 0) begin
            conv_valid = 1'b1;
            conv_data = 12'hFFF;
            spur = 1'b0;
          end
          cnt++;
          if (cnt >= ack_dly) begin
            conv_ack = 1'b1;
            ph = 1;
            cnt = 0;
            cur_ch = int'(conv_ch);
            hs_cnt++;
            hs_ch[conv_ch]++;
          end
        end
      end else begin
        cnt++;
        if (cnt >= val_dly) begin
          conv_valid = 1'b1;
          conv_data = (data_q.size() != 0) ? data_q.pop_front() : 12'(cur_ch * 100);
          ph = 0;
          cnt = 0;
          vld_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (sample_we) obs_q.push_back({sample_ch, sample_data});
    if (sweep_done) begin
      sd_cnt++;
      sd_times.push_back(cyc);
    end
    if (conv_req) req_cycles++;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_obs(input int bound, output bit ok, output samp_t s);
    ok = 1'b0;
    s = '0;
    for (int i = 0; i < bound && obs_q.size() == 0; i++) @(negedge clk);
    if (obs_q.size() != 0) begin
      ok = 1'b1;
      s = obs_q.pop_front();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({conv_req, conv_ch, sample_we, sample_ch, sample_data, sweep_done, busy, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b ch=%0d we=%b sch=%0d sdata=%0d done=%b busy=%b ovr=%b want all 0",
               conv_req, conv_ch, sample_we, sample_ch, sample_data, sweep_done, busy, overrun);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    samp_t o, e;
    int sd0;
    period = 20'd100; ch_mask = 8'b0000_0101; avg_log2 = 2'd0;
    ack_dly = 2; val_dly = 5;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({3'd0, 12'd0});
      exp_q.push_back({3'd2, 12'd200});
    end
    sd0 = sd_cnt;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_obs(300, ok, o);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e) begin
        failures++;
        $display("FAIL basic_sample%0d: got ok=%b ch=%0d data=%0d want ch=%0d data=%0d", k, ok, o.ch, o.data, e.ch, e.data);
      end
      if (k == 1) begin
        checks++;
        if (sd_cnt - sd0 !== 1) begin
          failures++;
          $display("FAIL basic_done_once: got %0d sweep_done pulses want 1", sd_cnt - sd0);
        end
      end
    end
    checks++;
    if (sd_cnt - sd0 < 2 || sd_times[$] - sd_times[$-1] !== 100) begin
      failures++;
      $display("FAIL basic_spacing: got pulses=%0d spacing=%0d want spacing 100", sd_cnt - sd0,
               (sd_times.size() > 1) ? sd_times[$] - sd_times[$-1] : -1);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL basic_overrun: got %b want 0", overrun);
    end
    enable = 1'b0;
    wait_idle();
  endtask

  task automatic test_oversample();
    bit ok;
    samp_t o, e;
    int h0;
    period = 20'd200; ch_mask = 8'h10; avg_log2 = 2'd2;
    ack_dly = 1; val_dly = 3;
    data_q = '{12'd10, 12'd11, 12'd12, 12'd14, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
    exp_q.push_back({3'd4, 12'd11});
    exp_q.push_back({3'd4, 12'd4095});
    h0 = hs_ch[4];
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_obs(400, ok, o);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e) begin
        failures++;
        $display("FAIL oversample_sample%0d: got ok=%b ch=%0d data=%0d want ch=%0d data=%0d", k, ok, o.ch, o.data, e.ch, e.data);
      end
      if (k == 0) begin
        checks++;
        if (hs_ch[4] - h0 !== 4) begin
          failures++;
          $display("FAIL oversample_requests: got %0d want 4", hs_ch[4] - h0);
        end
      end
    end
    enable = 1'b0;
    wait_idle();
    data_q.delete();
  endtask

  task automatic test_zero_mask();
    int sd0;
    period = 20'd10; ch_mask = 8'h00; avg_log2 = 2'd0;
    req_cycles = 0;
    busy_seen = 1'b0;
    sd0 = sd_cnt;
    enable = 1'b1;
    for (int i = 0; i < 100 && sd_cnt - sd0 < 4; i++) @(negedge clk);
    checks++;
    if (sd_cnt - sd0 < 4) begin
      failures++;
      $display("FAIL zero_mask_done: got %0d pulses want >= 4", sd_cnt - sd0);
    end else begin
      checks++;
      if (sd_times[$] - sd_times[$-1] !== 10) begin
        failures++;
        $display("FAIL zero_mask_spacing: got %0d want 10", sd_times[$] - sd_times[$-1]);
      end
    end
    checks++;
    if (req_cycles !== 0) begin
      failures++;
      $display("FAIL zero_mask_req: got %0d request cycles want 0", req_cycles);
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      failures++;
      $display("FAIL zero_mask_busy: got %b want 0", busy_seen);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun();
    bit ok;
    samp_t o, e;
    period = 20'd5; ch_mask = 8'h01; avg_log2 = 2'd0;
    ack_dly = 1; val_dly = 20;
    exp_q.push_back({3'd0, 12'd0});
    enable = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_before_tick: got %b want 0", overrun);
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    repeat (4) @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set_wins: got %b want 1", overrun);
    end
    @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: got %b want 0", overrun);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_reset_again: got %b want 1", overrun);
    end
    enable = 1'b0;
    wait_obs(100, ok, o);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o !== e) begin
      failures++;
      $display("FAIL overrun_sample: got ok=%b ch=%0d data=%0d want ch=%0d data=%0d", ok, o.ch, o.data, e.ch, e.data);
    end
    wait_idle();
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latched();
    bit ok;
    samp_t o, e;
    int h0, sd0;
    period = 20'd300; ch_mask = 8'b0000_0110; avg_log2 = 2'd1;
    ack_dly = 3; val_dly = 4;
    spur = 1'b1;
    exp_q.push_back({3'd1, 12'd100});
    exp_q.push_back({3'd2, 12'd200});
    h0 = hs_cnt;
    sd0 = sd_cnt;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    ch_mask = 8'hFF;
    avg_log2 = 2'd0;
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_obs(200, ok, o);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e) begin
        failures++;
        $display("FAIL latched_sample%0d: got ok=%b ch=%0d data=%0d want ch=%0d data=%0d", k, ok, o.ch, o.data, e.ch, e.data);
      end
    end
    checks++;
    if (hs_cnt - h0 !== 4) begin
      failures++;
      $display("FAIL latched_requests: got %0d want 4", hs_cnt - h0);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (obs_q.size() !== 0 || sd_cnt - sd0 !== 1) begin
      failures++;
      $display("FAIL latched_no_new_sweep: got extra_samples=%0d done_pulses=%0d want 0 and 1", obs_q.size(), sd_cnt - sd0);
    end
    spur = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    samp_t o, e;
    int h0;
    period = 20'd1000; ch_mask = 8'h08; avg_log2 = 2'd2;
    ack_dly = 1; val_dly = 10;
    data_q = '{12'd1000, 12'd1000, 12'd1000, 12'd1000};
    h0 = hs_cnt;
    enable = 1'b1;
    for (int i = 0; i < 200 && hs_cnt - h0 < 3; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || hs_cnt - h0 !== 3) begin
      failures++;
      $display("FAIL reset_mid_precond: got busy=%b handshakes=%0d want 1 and 3", busy, hs_cnt - h0);
    end
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if ({conv_req, conv_ch, sample_we, sample_ch, sample_data, sweep_done, busy, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got req=%b ch=%0d we=%b sch=%0d sdata=%0d done=%b busy=%b ovr=%b want all 0",
               conv_req, conv_ch, sample_we, sample_ch, sample_data, sweep_done, busy, overrun);
    end
    data_q = '{12'd5, 12'd6, 12'd7, 12'd9};
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_sample: got %0d samples want 0", obs_q.size());
    end
    reset_n = 1'b1;
    @(negedge clk);
    h0 = hs_ch[3];
    exp_q.push_back({3'd3, 12'd6});
    enable = 1'b1;
    wait_obs(300, ok, o);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o !== e) begin
      failures++;
      $display("FAIL reset_mid_sample: got ok=%b ch=%0d data=%0d want ch=%0d data=%0d", ok, o.ch, o.data, e.ch, e.data);
    end
    checks++;
    if (hs_ch[3] - h0 !== 4) begin
      failures++;
      $display("FAIL reset_mid_requests: got %0d want 4", hs_ch[3] - h0);
    end
    enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_oversample();
    test_zero_mask();
    test_overrun();
    test_latched();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imu_adc_scheduler.md
# imu_adc_scheduler

Sequences conversions on the IMU's shared serial ADC. On a programmable sample-period tick it sweeps an enabled channel set through the SPI conversion engine, oversamples each channel 1/2/4/8 times, and writes one averaged result per channel to the downstream register bank. It sits between the SPI ADC engine and the Avalon-visible gyro/magnetometer registers.

## Interface
- NUM_CH, 8, number of ADC channels (channel index width 3)
- DATA_W, 12, ADC result width
- PERIOD_W, 20, width of sample-period value
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; allows new sweeps to start
- period  in  PERIOD_W  clocks between sweep starts; 0 is treated as 1
- ch_mask  in  NUM_CH  bit i set = channel i converted in each sweep
- avg_log2  in  2  oversampling exponent; 2^avg_log2 conversions per channel
- clr_overrun  in  1  single-cycle pulse; clears overrun
- conv_req  out  1  conversion request to SPI engine
- conv_ch  out  3  channel for the current request
- conv_ack  in  1  engine accepts the request (transfer when conv_req & conv_ack)
- conv_valid  in  1  single-cycle pulse; conv_data valid
- conv_data  in  DATA_W  conversion result
- sample_we  out  1  single-cycle pulse; averaged sample valid
- sample_ch  out  3  channel of sample_data
- sample_data  out  DATA_W  averaged result
- sweep_done  out  1  single-cycle pulse at end of each sweep
- busy  out  1  high while a sweep is in progress
- overrun  out  1  sticky; a tick arrived while busy

## Operation
- All outputs registered. Reset values: every output 0; period counter 0; state IDLE; accumulator 0.
- Period timer: when enable=1 and counter=0, generate tick and reload max(period,1)-1; when enable=1 otherwise, decrement; when enable=0, hold counter at 0 (first tick on first enabled cycle).
- States: IDLE, ISSUE, WAIT_DATA, NEXT.
- IDLE: on tick, latch ch_mask and avg_log2 (sweep-local copies; input changes mid-sweep ignored), select lowest set mask bit, go to ISSUE, busy=1. Mask zero: pulse sweep_done, no request, stay IDLE.
- ISSUE: conv_req=1, conv_ch stable. On conv_req & conv_ack go to WAIT_DATA, conv_req drops next cycle.
- WAIT_DATA: on conv_valid, add conv_data to accumulator (DATA_W+3 bits, zero-extended, unsigned); increment conversion count. conv_valid outside WAIT_DATA is ignored.
- NEXT (entered same edge as valid): if count < 2^avg_log2, return to ISSUE on same channel. Else emit sample_we with sample_data = accumulator >> avg_log2 (truncating), clear accumulator and count, advance to next higher set bit; if none, pulse sweep_done, busy=0, return to IDLE.
- Channels always visited in ascending index order.
- Tick while busy: tick dropped, overrun set. Overrun set and clr_overrun same cycle: set wins.
- enable deasserted mid-sweep: current sweep completes; no new ticks.

## Timing
- Tick at edge N: conv_req high in cycle N+1.
- conv_ack sampled at edge A: conv_req low from cycle A+1; fastest valid accepted at edge A+1.
- Final conv_valid of a channel sampled at edge K: sample_we (and sweep_done if last channel) high in cycle K+1; next conv_req high in cycle K+2 (NEXT occupies one cycle).
- Intermediate oversample valid at edge K: next conv_req high in cycle K+2.
- Sweep length: sum over channels of 2^avg_log2 × (engine latency + 2) cycles plus 1.
- Asynchronous reset mid-sweep: all state and outputs return to reset values immediately; partial accumulation discarded; no sample_we issued.

## Test plan
- period=100, ch_mask=8'b0000_0101, avg_log2=0, engine ack after 2 cycles, valid 5 cycles later with data=ch×100 -> sample_we for ch0 data 0 then ch2 data 200, sweep_done once, sweeps start every 100 clocks, overrun=0.
- avg_log2=2, ch_mask=8'h10, data sequence 10,11,12,14 -> exactly 4 requests on ch4, one sample_we with data 11 (47>>2); data 4095×4 -> 4095 (no overflow).
- ch_mask=0, enable=1, period=10 -> sweep_done every 10 cycles, conv_req never asserted, busy stays 0.
- period=5 with engine latency 20 cycles -> overrun set at first tick during busy; clr_overrun pulse coinciding with another dropped tick leaves overrun=1; clr alone clears it.
- Change ch_mask and avg_log2 mid-sweep, spurious conv_valid while in ISSUE -> current sweep uses latched values, spurious valid not accumulated.
- Assert reset_n=0 while in WAIT_DATA after 2 of 4 oversamples -> all outputs 0 at once; after release and enable, first sample reflects only post-reset conversions.
